// File: rtl/tile_loop_ctrl_if.sv
// Command/handshake bundle for tile_loop_ctrl: walk configuration in,
// element stream and downstream counter strobes out.
interface tile_loop_ctrl_if #(
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ROW_W-1:0]  rows_cfg;
  logic [COL_W-1:0]  cols_cfg;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic              stall;
  logic              busy;
  logic              done;
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic [ROW_W-1:0]  row_idx;
  logic [COL_W-1:0]  col_idx;
  logic              cnt_clean;
  logic              cnt_en;

  modport master (
    output start, rows_cfg, cols_cfg, base_addr, stride, stall,
    input  busy, done, addr_valid, addr, row_idx, col_idx, cnt_clean, cnt_en
  );

  modport slave (
    input  start, rows_cfg, cols_cfg, base_addr, stride, stall,
    output busy, done, addr_valid, addr, row_idx, col_idx, cnt_clean, cnt_en
  );
endinterface

// File: rtl/tile_loop_ctrl.sv
// Row-major 2-D tile address walker with stall back-pressure. Row bases are
// accumulated by adding the stride, so no multiplier is needed.
module tile_loop_ctrl #(
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  tile_loop_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  rows_q, row_idx_q;
  logic [COL_W-1:0]  cols_q, col_idx_q;
  logic [ADDR_W-1:0] stride_q, row_base_q, addr_q;
  logic              cnt_clean_q;

  logic accept, cfg_zero, step, last_col, last_row;

  assign accept   = (state_q == IDLE) && bus.start;
  assign cfg_zero = (bus.rows_cfg == '0) || (bus.cols_cfg == '0);
  assign step     = (state_q == RUN) && !bus.stall;
  assign last_col = (col_idx_q == cols_q - COL_W'(1));
  assign last_row = (row_idx_q == rows_q - ROW_W'(1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = cfg_zero ? DONE : RUN;
      RUN:  if (step && last_col && last_row) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the datapath is a handful of flops, not a memory, so all of it is
  // reset; an aborted walk leaves nothing stale visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      addr_q      <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      cnt_clean_q <= 1'b0;
    end else begin
      cnt_clean_q <= accept;
      if (accept) begin
        rows_q     <= bus.rows_cfg;
        cols_q     <= bus.cols_cfg;
        stride_q   <= bus.stride;
        row_base_q <= bus.base_addr;
        addr_q     <= bus.base_addr;
        row_idx_q  <= '0;
        col_idx_q  <= '0;
      end else if (step && !(last_col && last_row)) begin
        if (!last_col) begin
          col_idx_q <= col_idx_q + COL_W'(1);
          addr_q    <= addr_q + ADDR_W'(1);
        end else begin
          // Next row starts one stride past the current row base.
          col_idx_q  <= '0;
          row_idx_q  <= row_idx_q + ROW_W'(1);
          row_base_q <= row_base_q + stride_q;
          addr_q     <= row_base_q + stride_q;
        end
      end
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.addr_valid = step;
  assign bus.cnt_en     = step;
  assign bus.cnt_clean  = cnt_clean_q;
  assign bus.addr       = addr_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.col_idx    = col_idx_q;

endmodule

// File: tb/tb_tile_loop_ctrl.sv
// Directed bench for tile_loop_ctrl: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_tile_loop_ctrl;

  typedef logic [15:0] addr_arr_t [8];

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  tile_loop_ctrl_if #(.ROW_W(8), .COL_W(8), .ADDR_W(16)) bus ();

  tile_loop_ctrl #(.ROW_W(8), .COL_W(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one walk. Bit i of stall_mask / start_mask applies to the i-th cycle
  // after start acceptance; start pulses carry junk configuration that must
  // be ignored. Ends sampled in the DONE cycle.
  task automatic do_walk(input string tag, input logic [7:0] rows, input logic [7:0] cols,
                         input logic [15:0] base, input logic [15:0] strd,
                         input logic [31:0] stall_mask, input logic [31:0] start_mask,
                         input addr_arr_t exp, input int n, input int run_exp);
    int run_cycles = 0;
    int vcnt       = 0;
    int en_cnt     = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.rows_cfg = rows; bus.cols_cfg = cols;
    bus.base_addr = base; bus.stride = strd; bus.stall = 1'b0;
    #1;
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    check({tag, "_idle_clean"}, 32'(bus.cnt_clean), 0);
    check({tag, "_idle_done"}, 32'(bus.done), 0);
    @(negedge clk);
    bus.start = 1'b0; bus.stall = stall_mask[0];
    #1;
    check({tag, "_clean_t1"}, 32'(bus.cnt_clean), 1);
    while (bus.busy && run_cycles < 30) begin
      if (bus.addr_valid) begin
        if (vcnt < n) begin
          check({tag, "_addr"}, 32'(bus.addr), 32'(exp[vcnt]));
          check({tag, "_row"}, 32'(bus.row_idx), 32'(vcnt / int'(cols)));
          check({tag, "_col"}, 32'(bus.col_idx), 32'(vcnt % int'(cols)));
        end
        vcnt++;
      end
      if (bus.cnt_en) en_cnt++;
      run_cycles++;
      @(negedge clk);
      bus.stall = stall_mask[run_cycles];
      bus.start = start_mask[run_cycles];
      if (bus.start) begin
        bus.rows_cfg = 8'd3; bus.cols_cfg = 8'd1; bus.base_addr = 16'hABCD; bus.stride = 16'h0005;
      end else begin
        bus.rows_cfg = rows; bus.cols_cfg = cols; bus.base_addr = base; bus.stride = strd;
      end
      #1;
      if (run_cycles == 1) check({tag, "_clean_t2"}, 32'(bus.cnt_clean), 0);
    end
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_done_busy"}, 32'(bus.busy), 0);
    check({tag, "_done_valid"}, 32'(bus.addr_valid), 0);
    check({tag, "_nvalid"}, 32'(vcnt), 32'(n));
    check({tag, "_cnt_en"}, 32'(en_cnt), 32'(n));
    check({tag, "_run_cycles"}, 32'(run_cycles), 32'(run_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int leak;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.rows_cfg = '0; bus.cols_cfg = '0;
    bus.base_addr = '0; bus.stride = '0; bus.stall = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_valid", 32'(bus.addr_valid), 0);
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_clean", 32'(bus.cnt_clean), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_walk("basic", 8'd2, 8'd3, 16'h0100, 16'h0010, 32'h0, 32'h0,
            '{16'h100, 16'h101, 16'h102, 16'h110, 16'h111, 16'h112, 16'h0, 16'h0}, 6, 6);
    do_walk("stall", 8'd2, 8'd3, 16'h0100, 16'h0010, 32'b1010, 32'h0,
            '{16'h100, 16'h101, 16'h102, 16'h110, 16'h111, 16'h112, 16'h0, 16'h0}, 6, 8);
    do_walk("zero", 8'd0, 8'd5, 16'h0300, 16'h0010, 32'h0, 32'h0,
            '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 0, 0);
    do_walk("wrap", 8'd1, 8'd4, 16'hFFFE, 16'h0001, 32'h0, 32'h0,
            '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 4);
    // Start pulsed mid-walk (cycle 2) and during DONE (cycle 6): both ignored.
    do_walk("busy_start", 8'd2, 8'd3, 16'h0200, 16'h0020, 32'h0, 32'h44,
            '{16'h200, 16'h201, 16'h202, 16'h220, 16'h221, 16'h222, 16'h0, 16'h0}, 6, 6);
    do_walk("b2b", 8'd1, 8'd2, 16'h0040, 16'h0000, 32'h0, 32'h0,
            '{16'h40, 16'h41, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 2);

    // Reset in the middle of a 2x3 walk, on its third element.
    @(negedge clk);
    bus.start = 1'b1; bus.rows_cfg = 8'd2; bus.cols_cfg = 8'd3;
    bus.base_addr = 16'h0100; bus.stride = 16'h0010; bus.stall = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mid_addr_before_rst", 32'(bus.addr), 32'h102);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.addr_valid), 0);
    check("mid_rst_cnt_en", 32'(bus.cnt_en), 0);
    check("mid_rst_addr", 32'(bus.addr), 0);
    check("mid_rst_row", 32'(bus.row_idx), 0);
    check("mid_rst_col", 32'(bus.col_idx), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    leak = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.addr_valid || bus.busy || bus.done) leak++;
    end
    check("post_rst_quiet", 32'(leak), 0);

    do_walk("recover", 8'd1, 8'd1, 16'h0007, 16'h0000, 32'h0, 32'h0,
            '{16'h7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 1);
    @(negedge clk);
    #1;
    check("final_idle_done", 32'(bus.done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_loop_ctrl.md
TILE_LOOP_CTRL -- requirements
Module: tile_loop_ctrl

Interface
REQ-001 SHALL have parameter ROW_W, default 8, meaning the bit width of the row count and row index.
REQ-002 SHALL have parameter COL_W, default 8, meaning the bit width of the column count and column index.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning the bit width of the address, base and stride.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request to begin a tile walk.
REQ-007 SHALL have port rows_cfg, input, ROW_W: number of rows.
REQ-008 SHALL have port cols_cfg, input, COL_W: number of columns.
REQ-009 SHALL have port base_addr, input, ADDR_W: address of element (0,0).
REQ-010 SHALL have port stride, input, ADDR_W: address step between rows.
REQ-011 SHALL have port stall, input, 1: downstream back-pressure.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: single-cycle pulse marking walk completion.
REQ-014 SHALL have port addr_valid, output, 1: addr, row_idx and col_idx are valid this cycle.
REQ-015 SHALL have port addr, output, ADDR_W: current element address.
REQ-016 SHALL have port row_idx, output, ROW_W: current row index.
REQ-017 SHALL have port col_idx, output, COL_W: current column index.
REQ-018 SHALL have port cnt_clean, output, 1: clear strobe to the downstream saturating element counter.
REQ-019 SHALL have port cnt_en, output, 1: increment strobe to the downstream counter.

Function
REQ-020 SHALL implement FSM states IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE with start=1 at edge T, latch rows_cfg, cols_cfg, base_addr and stride.
REQ-022 SHALL, on that same start acceptance at edge T, drive cnt_clean=1 for cycle T+1 only.
REQ-023 SHALL, on start acceptance with rows_cfg and cols_cfg both nonzero, enter RUN at T+1 with row_idx=0, col_idx=0 and addr=base_addr.
REQ-024 SHALL, on start acceptance with rows_cfg=0 or cols_cfg=0, enter DONE at T+1 with no addr_valid cycle.
REQ-025 SHALL drive addr_valid = (state==RUN) & ~stall combinationally.
REQ-026 SHALL drive cnt_en = addr_valid.
REQ-027 SHALL, while stall=1, hold addr, row_idx and col_idx unchanged.
REQ-028 SHALL, on an addr_valid edge with col_idx < cols-1, increment col_idx and addr by 1.
REQ-029 SHALL, on an addr_valid edge with col_idx = cols-1 and row_idx < rows-1, set col_idx=0, increment row_idx, and set addr = row base + stride, where row base is a registered base_addr + row_idx*stride accumulated incrementally with no multiplier.
REQ-030 SHALL, on an addr_valid edge at (rows-1, cols-1), enter DONE.
REQ-031 SHALL perform all address arithmetic modulo 2^ADDR_W, wrapping silently.
REQ-032 SHALL drive done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-033 SHALL ignore start in RUN and DONE, with no relatch and no cnt_clean.
REQ-034 SHALL allow start asserted in the cycle after DONE to be accepted, giving back-to-back walks.
REQ-035 SHALL drive busy=1 only in RUN.
REQ-036 SHALL emit exactly rows*cols addr_valid cycles per walk, independent of the stall pattern.

Reset
REQ-037 SHALL, on rst_n=0 at any time including mid-walk, immediately force state=IDLE.
REQ-038 SHALL, on reset, clear busy, done, cnt_clean, addr, row_idx, col_idx, the row base and all latched configuration to 0, so addr_valid=0 and cnt_en=0.
REQ-039 SHALL, after rst_n deasserts, stay in IDLE until a new start; no walk resumes.

Verification
REQ-040 SHALL cover a basic walk: rows=2, cols=3, base=0x100, stride=0x10, no stall -> addrs 0x100, 0x101, 0x102, 0x110, 0x111, 0x112 on consecutive cycles, then done one cycle later.
REQ-041 SHALL cover stalls: the same config with stall=1 on the 2nd and 4th RUN cycles -> same 6 addresses, 8 RUN cycles, cnt_en count = 6.
REQ-042 SHALL cover a zero config: rows=0, cols=5 -> cnt_clean at T+1, done at T+1, addr_valid never high.
REQ-043 SHALL cover wrap: base=0xFFFE, stride=0x0001, rows=1, cols=4, ADDR_W=16 -> addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-044 SHALL cover a start while busy: start pulsed mid-walk -> ignored, walk completes unchanged; a start on the cycle after done -> new walk with cnt_clean.
REQ-045 SHALL cover reset mid-walk: rst_n=0 at element 3 of a 2x3 walk -> outputs zero asynchronously; after release, no addr_valid until the next start.
